// File: rtl/shiftreg_seq_multi.sv
// Serial shift-register sequencer: one static word, then one or more dynamic
// frames shifted on NCH parallel channels, each frame closed by an en_fin latch pulse.
module shiftreg_seq_multi #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int NCH        = 1,
  parameter int CLKDIV     = 2,
  parameter int LATCH_CYC  = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     STOP,
  input  logic                     MODE,
  input  logic [SIZESRSTAT-1:0]    STAT_DATA,
  input  logic [NCH*SIZESRDYN-1:0] DYN_DATA,
  output logic                     sel_stat,
  output logic                     sel_dyn,
  output logic                     sr_clk,
  output logic [NCH-1:0]           signal_out,
  output logic                     en_fin,
  output logic                     dyn_ack,
  output logic                     busy,
  output logic                     done
);

  localparam int MAX_SD  = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
  localparam int BIT_MAX = (MAX_SD > LATCH_CYC) ? MAX_SD : LATCH_CYC;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int DIV_W   = $clog2(CLKDIV);

  localparam logic [BIT_W-1:0] STAT_LAST  = BIT_W'(SIZESRSTAT - 1);
  localparam logic [BIT_W-1:0] DYN_LAST   = BIT_W'(SIZESRDYN - 1);
  localparam logic [BIT_W-1:0] LATCH_LAST = BIT_W'(LATCH_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKDIV - 1);

  typedef enum logic [2:0] {IDLE, STAT, DYN, LATCH, DONE} state_e;

  state_e                           state_q, state_d;
  logic [SIZESRSTAT-1:0]            stat_sr_q, stat_sr_d;
  logic [NCH-1:0][SIZESRDYN-1:0]    dyn_sr_q, dyn_sr_d;
  logic                             mode_q, mode_d;
  logic                             stop_pend_q, stop_pend_d;
  logic [DIV_W-1:0]                 div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]                 bit_cnt_q, bit_cnt_d;

  logic           sel_stat_q, sel_stat_d;
  logic           sel_dyn_q, sel_dyn_d;
  logic           sr_clk_q, sr_clk_d;
  logic [NCH-1:0] signal_out_q, signal_out_d;
  logic           en_fin_q, en_fin_d;
  logic           dyn_ack_q, dyn_ack_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic period_end;
  assign period_end = (div_cnt_q == DIV_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    stat_sr_d   = stat_sr_q;
    dyn_sr_d    = dyn_sr_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    dyn_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = STAT;
          stat_sr_d = STAT_DATA;
          dyn_sr_d  = DYN_DATA;
          mode_d    = MODE;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          dyn_ack_d = 1'b1;
        end
      end
      STAT: begin
        stop_pend_d = stop_pend_q | STOP;
        if (period_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == STAT_LAST) begin
            state_d   = DYN;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            stat_sr_d = stat_sr_q << 1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      DYN: begin
        stop_pend_d = stop_pend_q | STOP;
        if (period_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == DYN_LAST) begin
            state_d   = LATCH;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            for (int c = 0; c < NCH; c++) dyn_sr_d[c] = dyn_sr_q[c] << 1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        stop_pend_d = stop_pend_q | STOP;
        if (bit_cnt_q == LATCH_LAST) begin
          // The continue decision uses the flag as it stood when dyn_ack was issued.
          if (mode_q && !stop_pend_q) begin
            state_d   = DYN;
            dyn_sr_d  = DYN_DATA;
            div_cnt_d = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == LATCH && bit_cnt_d == LATCH_LAST && mode_q && !stop_pend_d)
      dyn_ack_d = 1'b1;

    sel_stat_d   = (state_d == STAT);
    sel_dyn_d    = (state_d == DYN);
    sr_clk_d     = (state_d == STAT || state_d == DYN) && (div_cnt_d == DIV_LAST);
    en_fin_d     = (state_d == LATCH);
    busy_d       = (state_d == STAT || state_d == DYN || state_d == LATCH);
    done_d       = (state_d == DONE);
    signal_out_d = '0;
    if (state_d == STAT) signal_out_d[0] = stat_sr_d[SIZESRSTAT-1];
    if (state_d == DYN)
      for (int c = 0; c < NCH; c++) signal_out_d[c] = dyn_sr_d[c][SIZESRDYN-1];
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) begin
      state_q      <= IDLE;
      stat_sr_q    <= '0;
      dyn_sr_q     <= '0;
      mode_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sel_stat_q   <= 1'b0;
      sel_dyn_q    <= 1'b0;
      sr_clk_q     <= 1'b0;
      signal_out_q <= '0;
      en_fin_q     <= 1'b0;
      dyn_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stat_sr_q    <= stat_sr_d;
      dyn_sr_q     <= dyn_sr_d;
      mode_q       <= mode_d;
      stop_pend_q  <= stop_pend_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sel_stat_q   <= sel_stat_d;
      sel_dyn_q    <= sel_dyn_d;
      sr_clk_q     <= sr_clk_d;
      signal_out_q <= signal_out_d;
      en_fin_q     <= en_fin_d;
      dyn_ack_q    <= dyn_ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign sel_stat   = sel_stat_q;
  assign sel_dyn    = sel_dyn_q;
  assign sr_clk     = sr_clk_q;
  assign signal_out = signal_out_q;
  assign en_fin     = en_fin_q;
  assign dyn_ack    = dyn_ack_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_shiftreg_seq_multi.sv
// Directed bench for shiftreg_seq_multi with 8-bit static, 2x4-bit dynamic,
// CLKDIV=2, LATCH_CYC=2; every output is compared every cycle against hand-derived vectors.
module tb_shiftreg_seq_multi;

  localparam int SIZESRSTAT = 8;
  localparam int SIZESRDYN  = 4;
  localparam int NCH        = 2;
  localparam int CLKDIV     = 2;
  localparam int LATCH_CYC  = 2;

  logic                     CLK = 1'b0;
  logic                     RST, START, STOP, MODE;
  logic [SIZESRSTAT-1:0]    STAT_DATA;
  logic [NCH*SIZESRDYN-1:0] DYN_DATA;
  logic                     sel_stat, sel_dyn, sr_clk, en_fin, dyn_ack, busy, done;
  logic [NCH-1:0]           signal_out;

  int n_checks = 0;
  int n_fail   = 0;
  int stat_clks, dyn_clks;

  always #5 CLK = ~CLK;

  shiftreg_seq_multi #(
    .SIZESRSTAT(SIZESRSTAT), .SIZESRDYN(SIZESRDYN), .NCH(NCH),
    .CLKDIV(CLKDIV), .LATCH_CYC(LATCH_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .MODE(MODE),
    .STAT_DATA(STAT_DATA), .DYN_DATA(DYN_DATA),
    .sel_stat(sel_stat), .sel_dyn(sel_dyn), .sr_clk(sr_clk),
    .signal_out(signal_out), .en_fin(en_fin), .dyn_ack(dyn_ack),
    .busy(busy), .done(done)
  );

  // Output vector: {sel_stat, sel_dyn, sr_clk, so[1], so[0], en_fin, dyn_ack, busy, done}
  logic [8:0] obs;
  assign obs = {sel_stat, sel_dyn, sr_clk, signal_out[1], signal_out[0],
                en_fin, dyn_ack, busy, done};

  function automatic logic [8:0] mk(input logic ss, sd, sc, so1, so0, ef, da, bz, dn);
    return {ss, sd, sc, so1, so0, ef, da, bz, dn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // 16 static cycles, MSB first, sr_clk on the second cycle of each bit.
  task automatic chk_stat(input logic [7:0] s);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stat_c%0d", i), obs,
            mk(1'b1, 1'b0, (i % 2 == 1), 1'b0, s[7 - i/2], 1'b0, (i == 0), 1'b1, 1'b0));
      if (sr_clk && sel_stat) stat_clks++;
      tick();
    end
  endtask

  // 8 dynamic cycles; ch0 = d[3:0], ch1 = d[7:4], both MSB first.
  task automatic chk_dyn(input logic [7:0] d, input int stop_at, input int chg_at,
                         input logic [7:0] chg_val);
    for (int i = 0; i < 8; i++) begin
      int b;
      b = 3 - i/2;
      check($sformatf("dyn_c%0d", i), obs,
            mk(1'b0, 1'b1, (i % 2 == 1), d[4 + b], d[b], 1'b0, 1'b0, 1'b1, 1'b0));
      if (sr_clk && sel_dyn) dyn_clks++;
      if (i == stop_at) STOP = 1'b1;
      if (i == chg_at) DYN_DATA = chg_val;
      tick();
      STOP = 1'b0;
    end
  endtask

  task automatic chk_latch(input logic ack_last);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("latch_c%0d", i), obs,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ack_last && (i == 1), 1'b1, 1'b0));
      tick();
    end
  endtask

  task automatic chk_done();
    check("done", obs, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
  endtask

  task automatic chk_idle(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("idle_c%0d", i), obs, 9'd0);
      tick();
    end
  endtask

  task automatic start_seq(input logic m, input logic [7:0] s, input logic [7:0] d);
    MODE      = m;
    STAT_DATA = s;
    DYN_DATA  = d;
    START     = 1'b1;
    tick();
    START     = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b1; STOP = 1'b0; MODE = 1'b0;
    STAT_DATA = '0; DYN_DATA = '0;
    @(negedge CLK);
    tick();
    tick();
    check("reset_outputs", obs, 9'd0);
    RST   = 1'b0;
    START = 1'b0;
    chk_idle(2);

    // Single sequence: A5 static, 3C dynamic; done seen 26 edges after the START edge.
    stat_clks = 0; dyn_clks = 0;
    start_seq(1'b0, 8'hA5, 8'h3C);
    chk_stat(8'hA5);
    chk_dyn(8'h3C, -1, -1, 8'h00);
    chk_latch(1'b0);
    chk_done();
    chk_idle(2);
    check("stat_sr_clk_count", stat_clks, 8);
    check("dyn_sr_clk_count", dyn_clks, 4);

    // Continuous: data changes during frame 1, STOP in the middle of frame 3.
    start_seq(1'b1, 8'hA5, 8'h3C);
    chk_stat(8'hA5);
    chk_dyn(8'h3C, -1, 3, 8'hC3);
    chk_latch(1'b1);
    chk_dyn(8'hC3, -1, -1, 8'h00);
    chk_latch(1'b1);
    chk_dyn(8'hC3, 4, -1, 8'h00);
    chk_latch(1'b0);
    chk_done();
    chk_idle(4);

    // Reset in the middle of the static phase, then a clean sequence.
    start_seq(1'b0, 8'hA5, 8'h3C);
    repeat (5) tick();
    RST = 1'b1;
    tick();
    check("reset_mid_stat", obs, 9'd0);
    RST = 1'b0;
    chk_idle(2);
    start_seq(1'b0, 8'h96, 8'h5A);
    chk_stat(8'h96);
    chk_dyn(8'h5A, -1, -1, 8'h00);
    chk_latch(1'b0);
    chk_done();
    chk_idle(1);

    // START held high: no restart while busy, next sequence from the first IDLE cycle.
    MODE = 1'b0; STAT_DATA = 8'h0F; DYN_DATA = 8'hE1; START = 1'b1;
    tick();
    chk_stat(8'h0F);
    chk_dyn(8'hE1, -1, -1, 8'h00);
    chk_latch(1'b0);
    chk_done();
    chk_idle(1);
    chk_stat(8'h0F);
    START = 1'b0;
    RST   = 1'b1;
    tick();
    check("final_reset", obs, 9'd0);
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
